// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use/RAW stalls,
// taken-branch flushes, EX operand forward selects and saturating statistics.
module pipeline_hazard_ctrl #(
   parameter int FORWARDING = 1,
   parameter int REG_AW     = 5,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_branch,
   input  logic              ex_zero,
   input  logic [REG_AW-1:0] dm_rd,
   input  logic              dm_reg_write,
   output logic              pc_write_en,
   output logic              if_id_write_en,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, BR_FLUSH = 2'b10} state_t;

   localparam bit FWD = (FORWARDING != 0);

   state_t     st;
   logic [1:0] stall_left;
   logic       ex_match_rs, ex_match_rt, dm_match_rs, dm_match_rt;
   logic       ex_match, dm_match, taken, hazard;
   logic [1:0] stall_load;

   assign state = st;

   assign ex_match_rs = id_valid & id_uses_rs & ex_reg_write & (ex_rd == id_rs) & (id_rs != '0);
   assign ex_match_rt = id_valid & id_uses_rt & ex_reg_write & (ex_rd == id_rt) & (id_rt != '0);
   assign dm_match_rs = id_valid & id_uses_rs & dm_reg_write & (dm_rd == id_rs) & (id_rs != '0);
   assign dm_match_rt = id_valid & id_uses_rt & dm_reg_write & (dm_rd == id_rt) & (id_rt != '0);
   assign ex_match    = ex_match_rs | ex_match_rt;
   assign dm_match    = dm_match_rs | dm_match_rt;
   assign taken       = ex_branch & ex_zero;
   assign hazard      = FWD ? (ex_mem_read & ex_match) : (ex_match | dm_match);

   // stall_left counts stall cycles still owed after the detecting cycle: a load-use
   // (forwarding) or DM-only RAW is covered by that cycle alone, an unforwarded EX RAW needs one more.
   assign stall_load  = (!FWD && ex_match) ? 2'd1 : 2'd0;

   always_comb begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_bubble   = 1'b0;
      if (reset) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         if_id_flush    = 1'b1;
         id_ex_bubble   = 1'b1;
      end else if (taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else begin
         case (st)
            RUN: if (hazard) begin
               pc_write_en    = 1'b0;
               if_id_write_en = 1'b0;
               id_ex_bubble   = 1'b1;
            end
            STALL: begin
               pc_write_en    = 1'b0;
               if_id_write_en = 1'b0;
               id_ex_bubble   = 1'b1;
            end
            BR_FLUSH: if_id_flush = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st           <= RUN;
         stall_left   <= '0;
         fwd_a        <= '0;
         fwd_b        <= '0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_write_en && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);

         if (taken) begin
            st         <= BR_FLUSH;
            stall_left <= '0;
            if (flush_count != '1)
               flush_count <= flush_count + CNT_W'(1);
         end else begin
            case (st)
               RUN: if (hazard) begin
                  stall_left <= stall_load;
                  st         <= (stall_load != '0) ? STALL : RUN;
               end
               STALL: begin
                  stall_left <= stall_left - 2'd1;
                  st         <= (stall_left <= 2'd1) ? RUN : STALL;
               end
               default: st <= RUN;
            endcase
         end

         if (!FWD || id_ex_bubble) begin
            fwd_a <= '0;
            fwd_b <= '0;
         end else if (if_id_write_en) begin
            fwd_a <= ex_match_rs ? 2'b01 : (dm_match_rs ? 2'b10 : 2'b00);
            fwd_b <= ex_match_rt ? 2'b01 : (dm_match_rt ? 2'b10 : 2'b00);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one forwarding and one non-forwarding
// instance share the stimulus; expected values are hand-computed per step.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_uses_rs, id_uses_rt;
   logic [4:0] id_rs, id_rt, ex_rd, dm_rd;
   logic       ex_reg_write, ex_mem_read, ex_branch, ex_zero, dm_reg_write;
   logic       br_force_n;

   logic        pc_1, ifw_1, flush_1, bub_1, pc_0, ifw_0, flush_0, bub_0;
   logic [1:0]  fwd_a_1, fwd_b_1, fwd_a_0, fwd_b_0, state_1, state_0;
   logic [15:0] stalls_1, flushes_1, stalls_0, flushes_0;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.FORWARDING(1), .REG_AW(5), .CNT_W(16)) u_fwd (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_branch(ex_branch),
      .ex_zero(ex_zero), .dm_rd(dm_rd), .dm_reg_write(dm_reg_write),
      .pc_write_en(pc_1), .if_id_write_en(ifw_1), .if_id_flush(flush_1),
      .id_ex_bubble(bub_1), .fwd_a(fwd_a_1), .fwd_b(fwd_b_1),
      .stall_cycles(stalls_1), .flush_count(flushes_1), .state(state_1));

   pipeline_hazard_ctrl #(.FORWARDING(0), .REG_AW(5), .CNT_W(16)) u_nofwd (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_branch(ex_branch | br_force_n),
      .ex_zero(ex_zero), .dm_rd(dm_rd), .dm_reg_write(dm_reg_write),
      .pc_write_en(pc_0), .if_id_write_en(ifw_0), .if_id_flush(flush_0),
      .id_ex_bubble(bub_0), .fwd_a(fwd_a_0), .fwd_b(fwd_b_0),
      .stall_cycles(stalls_0), .flush_count(flushes_0), .state(state_0));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_rs = 0; id_rt = 0;
      ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_branch = 0; ex_zero = 0;
      dm_rd = 0; dm_reg_write = 0; br_force_n = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      repeat (3) tick();
      reset = 0;
      #1;
   endtask

   initial begin
      // reset held three cycles
      idle();
      reset = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_bubble", bub_1, 1);
         chk("rst_flush", flush_1, 1);
         chk("rst_pc", pc_1, 0);
         chk("rst_ifw", ifw_1, 0);
      end
      reset = 0;
      #1;
      chk("rel_state", state_1, 0);
      chk("rel_pc", pc_1, 1);
      chk("rel_ifw", ifw_1, 1);
      chk("rel_bub", bub_1, 0);
      chk("rel_fwd", {fwd_a_1, fwd_b_1}, 0);
      chk("rel_cnt", {stalls_1, flushes_1}, 0);

      // load-use with forwarding: lw $2 in EX, add $3,$2,$4 in ID
      id_valid = 1; id_rs = 2; id_rt = 4; id_uses_rs = 1; id_uses_rt = 1;
      ex_rd = 2; ex_reg_write = 1; ex_mem_read = 1;
      #1;
      chk("lu_pc", pc_1, 0);
      chk("lu_bub", bub_1, 1);
      tick();
      chk("lu_state", state_1, 0);
      ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; dm_rd = 2; dm_reg_write = 1;
      #1;
      chk("lu_pc2", pc_1, 1);
      tick();
      chk("lu_fwd_a", fwd_a_1, 2'b10);
      chk("lu_fwd_b", fwd_b_1, 2'b00);
      chk("lu_stalls", stalls_1, 1);

      // EX-to-EX forward, EX beats DM; then $0 and invalid ID
      do_reset();
      id_valid = 1; id_rs = 5; id_rt = 5; id_uses_rs = 1; id_uses_rt = 1;
      ex_rd = 5; ex_reg_write = 1; dm_rd = 5; dm_reg_write = 1;
      #1;
      chk("fw_pc", pc_1, 1);
      tick();
      chk("fw_fwd_a", fwd_a_1, 2'b01);
      chk("fw_fwd_b", fwd_b_1, 2'b01);
      chk("fw_stalls", stalls_1, 0);
      chk("nf_fwd_zero", {fwd_a_0, fwd_b_0}, 0);
      id_rs = 0; id_rt = 0; ex_rd = 0; dm_rd = 0;
      tick();
      chk("r0_fwd", {fwd_a_1, fwd_b_1}, 0);
      id_rs = 5; id_rt = 5; ex_rd = 5; dm_rd = 5; id_valid = 0;
      tick();
      chk("inv_fwd", {fwd_a_1, fwd_b_1}, 0);

      // no forwarding: EX RAW stalls 2, DM-only RAW stalls 1
      do_reset();
      id_valid = 1; id_rs = 3; id_uses_rs = 1; ex_rd = 3; ex_reg_write = 1;
      #1;
      chk("nf_pc_a", pc_0, 0);
      chk("nf_bub_a", bub_0, 1);
      tick();
      chk("nf_state_stall", state_0, 2'b01);
      ex_reg_write = 0; dm_rd = 3; dm_reg_write = 1;
      #1;
      chk("nf_pc_b", pc_0, 0);
      tick();
      chk("nf_state_run", state_0, 2'b00);
      dm_reg_write = 0;
      #1;
      chk("nf_pc_c", pc_0, 1);
      chk("nf_stalls2", stalls_0, 2);
      id_rs = 7; dm_rd = 7; dm_reg_write = 1;
      #1;
      chk("dm_pc", pc_0, 0);
      tick();
      chk("dm_state", state_0, 2'b00);
      dm_reg_write = 0;
      #1;
      chk("dm_pc2", pc_0, 1);
      chk("dm_stalls3", stalls_0, 3);

      // taken branch
      do_reset();
      ex_branch = 1; ex_zero = 1;
      #1;
      chk("br_flush", flush_1, 1);
      chk("br_bub", bub_1, 1);
      chk("br_pc", pc_1, 1);
      tick();
      chk("br_state", state_1, 2'b10);
      chk("br_count", flushes_1, 1);
      ex_branch = 0;
      #1;
      chk("brf_flush", flush_1, 1);
      chk("brf_bub", bub_1, 0);
      chk("brf_pc", pc_1, 1);
      tick();
      chk("brf_state", state_1, 2'b00);
      chk("brf_flush0", flush_1, 0);
      chk("brf_count", flushes_1, 1);

      // branch arriving during STALL aborts it
      do_reset();
      id_valid = 1; id_rs = 3; id_uses_rs = 1; ex_rd = 3; ex_reg_write = 1;
      tick();
      chk("bs_stall", state_0, 2'b01);
      ex_branch = 1; ex_zero = 1;
      #1;
      chk("bs_pc", pc_0, 1);
      chk("bs_flush", flush_0, 1);
      tick();
      chk("bs_state", state_0, 2'b10);
      ex_branch = 0; ex_reg_write = 0;
      tick();
      chk("bs_run", state_0, 2'b00);
      chk("bs_stalls", stalls_0, 1);
      chk("bs_flushes", flushes_0, 1);

      // saturation: u_fwd stalls every cycle, u_nofwd sees a taken branch every cycle
      do_reset();
      id_valid = 1; id_rs = 2; id_uses_rs = 1;
      ex_rd = 2; ex_reg_write = 1; ex_mem_read = 1; ex_zero = 1; br_force_n = 1;
      repeat (65540) tick();
      chk("sat_stalls", stalls_1, 16'hFFFF);
      chk("sat_flushes", flushes_0, 16'hFFFF);
      chk("sat_stalls_nf", stalls_0, 0);
      chk("sat_flushes_f", flushes_1, 0);

      // reset asserted mid-STALL
      br_force_n = 0; ex_zero = 0; ex_mem_read = 0;
      tick();
      tick();
      chk("ms_stall", state_0, 2'b01);
      reset = 1;
      #1;
      chk("ms_state", state_0, 2'b00);
      chk("ms_cnt", {stalls_0, flushes_0}, 0);
      chk("ms_cnt_f", stalls_1, 0);
      chk("ms_pc", pc_0, 0);
      idle();
      tick();
      reset = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
